// File: rtl/mul_share_arb_if.sv
// mul_share_arb_if: requester-side bus of the shared multiplier arbiter.
interface mul_share_arb_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] opa_flat;
  logic [NREQ*W-1:0] opb_flat;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              busy;
  modport master (output req, opa_flat, opb_flat, input gnt, rsp_valid, rsp_data, busy);
  modport slave  (input req, opa_flat, opb_flat, output gnt, rsp_valid, rsp_data, busy);
endinterface

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin sequencer sharing one repeated-addition multiplier datapath.
// Define MUL_SWAP_EN to iterate over the smaller operand.
module mul_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  mul_share_arb_if.slave      bus,
  output logic [W-1:0]        datain,
  output logic                lda,
  output logic                ldb,
  output logic                ldp,
  output logic                clrp,
  output logic                decb,
  input  logic                eqz,
  input  logic [W-1:0]        pin
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [2:0] {IDLE, LDA, LDB, MUL, DONE} state_t;
  state_t state, state_n;
  logic [NREQ-1:0] gnt, gnt_n;
  logic [PW-1:0] ptr, ptr_n, sel, idx, gi;
  logic [W-1:0] rsp, rsp_n, opa_g, opb_g, ld_a, ld_b;
  logic ok;
  always_comb begin
    sel = ptr;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (bus.req[idx]) sel = idx;
    end
  end
  always_comb begin
    gi = '0;
    for (int k = 0; k < NREQ; k++) if (gnt[PW'(k)]) gi = PW'(k);
  end
  assign ok    = $onehot(gnt);
  assign opa_g = bus.opa_flat[gi*W +: W];
  assign opb_g = bus.opb_flat[gi*W +: W];
`ifdef MUL_SWAP_EN
  logic swap;
  logic [W-1:0] opa_s, opb_s;
  assign opa_s = bus.opa_flat[sel*W +: W];
  assign opb_s = bus.opb_flat[sel*W +: W];
  // captured every IDLE cycle; only the value from the granting cycle is used
  always_ff @(posedge clk or posedge rst)
    if (rst) swap <= 1'b0;
    else if (state == IDLE) swap <= opb_s > opa_s;
  assign ld_a = swap ? opb_g : opa_g;
  assign ld_b = swap ? opa_g : opb_g;
`else
  assign ld_a = opa_g;
  assign ld_b = opb_g;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      rsp   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      ptr   <= ptr_n;
      rsp   <= rsp_n;
    end
  // a corrupted grant vector outside IDLE abandons the operation
  always_comb begin
    state_n = IDLE;
    gnt_n   = ok ? gnt : '0;
    ptr_n   = ptr;
    rsp_n   = rsp;
    lda     = 1'b0;
    ldb     = 1'b0;
    clrp    = 1'b0;
    ldp     = 1'b0;
    decb    = 1'b0;
    datain  = '0;
    case (state)
      IDLE: begin
        gnt_n   = (|bus.req) ? NREQ'(1) << sel : '0;
        state_n = (|bus.req) ? LDA : IDLE;
      end
      LDA: begin
        lda     = 1'b1;
        clrp    = 1'b1;
        datain  = ld_a;
        state_n = ok ? LDB : IDLE;
      end
      LDB: begin
        ldb     = 1'b1;
        datain  = ld_b;
        state_n = ok ? MUL : IDLE;
      end
      MUL: begin
        ldp     = ~eqz;
        decb    = ~eqz;
        rsp_n   = eqz ? pin : rsp;
        state_n = !ok ? IDLE : eqz ? DONE : MUL;
      end
      DONE: begin
        gnt_n = '0;
        ptr_n = (gi == PW'(NREQ - 1)) ? '0 : gi + 1'b1;
      end
      default: gnt_n = '0;
    endcase
  end
  assign bus.gnt       = gnt;
  assign bus.rsp_valid = (state == DONE) ? gnt : '0;
  assign bus.rsp_data  = rsp;
  assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: randomized bench for mul_share_arb with a datapath model and reference scoreboard.
module tb_mul_share_arb;
  localparam int NREQ = 4;
  localparam int W    = 16;
`ifdef MUL_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [W-1:0] datain, pin, a_r, b_r, p_r;
  logic lda, ldb, ldp, clrp, decb, eqz;
  mul_share_arb_if #(.NREQ(NREQ), .W(W)) bus ();
  mul_share_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .datain(datain), .lda(lda), .ldb(ldb),
    .ldp(ldp), .clrp(clrp), .decb(decb), .eqz(eqz), .pin(pin)
  );
  always @(posedge clk) begin
    if (lda) a_r <= datain;
    if (ldb) b_r <= datain;
    else if (decb) b_r <= b_r - 1'b1;
    if (clrp) p_r <= '0;
    else if (ldp) p_r <= p_r + a_r;
  end
  assign eqz = b_r == '0;
  assign pin = p_r;
  int checks = 0;
  int failures = 0;
  logic [W-1:0] a_v [NREQ];
  logic [W-1:0] b_v [NREQ];
  logic [NREQ-1:0] req_v;
  int mptr;
  int w;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction
  function automatic logic [W-1:0] rnd_a();
    return ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 20));
  endfunction
  function automatic logic [W-1:0] rnd_b();
    return W'($urandom_range(0, 12));
  endfunction
  task automatic drive();
    bus.req = req_v;
    for (int k = 0; k < NREQ; k++) begin
      bus.opa_flat[k*W +: W] = a_v[k];
      bus.opb_flat[k*W +: W] = b_v[k];
    end
  endtask
  // Entered at a falling edge of an IDLE cycle; returns after the IDLE cycle following DONE.
  task automatic serve(output int win);
    int n, cyc, ldpc, decc;
    logic [31:0] prod;
    bit got, sw;
    drive();
    win  = pick(req_v, mptr);
    sw   = SWAP && (b_v[win] > a_v[win]);
    n    = sw ? int'(a_v[win]) : int'(b_v[win]);
    prod = a_v[win] * b_v[win];
    cyc = 0; ldpc = 0; decc = 0; got = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check("gnt", 32'(bus.gnt), 32'(1) << win);
        check("lda_cycle", {lda, clrp, ldb}, 3'b110);
        check("datain_a", 32'(datain), 32'(sw ? b_v[win] : a_v[win]));
      end
      if (cyc == 2) begin
        check("ldb_cycle", {lda, clrp, ldb}, 3'b001);
        check("datain_b", 32'(datain), 32'(sw ? a_v[win] : b_v[win]));
      end
      ldpc += int'(ldp);
      decc += int'(decb);
      got = bus.rsp_valid != '0;
    end
    check("latency", cyc, n + 4);
    check("rsp_valid", 32'(bus.rsp_valid), 32'(1) << win);
    check("rsp_data", 32'(bus.rsp_data), {16'h0, prod[15:0]});
    check("ldp_count", ldpc, n);
    check("decb_count", decc, n);
    @(negedge clk);
    check("pulse_end", {bus.rsp_valid, bus.busy, bus.gnt}, '0);
    mptr = (win + 1) % NREQ;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    req_v = '0;
    for (int k = 0; k < NREQ; k++) begin a_v[k] = '0; b_v[k] = '0; end
    drive();
    mptr = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_data}, 0);
    check("rst_strobes", {lda, ldb, ldp, clrp, decb, datain}, 0);
    rst = 1'b0;
    a_v[0] = 16'd7; b_v[0] = 16'd5; req_v = 4'b0001;
    serve(w);
    a_v[2] = 16'd9; b_v[2] = 16'd0; req_v = 4'b0100;
    serve(w);
    for (int k = 0; k < NREQ; k++) begin a_v[k] = 16'd3; b_v[k] = 16'd2; end
    req_v = 4'b1111;
    repeat (5) serve(w);
    a_v[3] = 16'hFFFF; b_v[3] = 16'd3; req_v = 4'b1000;
    serve(w);
    a_v[1] = 16'd4; b_v[1] = 16'd10; req_v = 4'b0010;
    drive();
    repeat (6) @(negedge clk);
    check("mid_busy", {bus.busy, ldp, bus.gnt}, {2'b11, 4'b0010});
    #2 rst = 1'b1;
    #1;
    check("async_rst_outs", {bus.busy, bus.gnt, bus.rsp_valid, ldp, decb, lda, ldb, clrp}, 0);
    check("async_rst_data", {datain, bus.rsp_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    serve(w);
    a_v[0] = 16'd2; b_v[0] = 16'd50; req_v = 4'b0001;
    serve(w);
    req_v = '0;
    for (int k = 0; k < NREQ; k++) begin
      a_v[k] = rnd_a(); b_v[k] = rnd_b(); req_v[k] = 1'($urandom_range(0, 1));
    end
    if (req_v == '0) req_v[$urandom_range(0, NREQ - 1)] = 1'b1;
    for (int it = 0; it < 25; it++) begin
      serve(w);
      a_v[w] = rnd_a(); b_v[w] = rnd_b(); req_v[w] = 1'($urandom_range(0, 1));
      for (int k = 0; k < NREQ; k++)
        if (k != w && !req_v[k]) begin
          a_v[k] = rnd_a(); b_v[k] = rnd_b(); req_v[k] = 1'($urandom_range(0, 1));
        end
      if (req_v == '0) req_v[$urandom_range(0, NREQ - 1)] = 1'b1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
